// File: rtl/multi_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// multi_cycle_ctrl
//
// Main control FSM for the multi-cycle MIPS datapath. Every instruction is
// stepped through FETCH, DECODE and then an opcode-specific execute / memory /
// write-back path before returning to FETCH. The block drives every datapath
// mux select and enable, plus the 2-bit ALUOp consumed by the ALU control
// decoder.
//
// Memory handshake: in FETCH, MEMRD and MEMWR the read/write strobe is held
// high for as long as the FSM stays in that state. The shared memory signals
// completion by raising mem_ready_i for one cycle; that cycle is the transfer
// cycle and the FSM advances on the following clock edge. mem_ready_i is
// ignored in every other state.
//
// Optional feature (compile-time macro):
//   CTRL_JUMP_EN  defined   -> opcode 000010 (j) dispatches to the JUMP state.
//                 undefined -> no JUMP state; 000010 is treated as illegal and
//                              pc_src_o never drives 2'b10.
//
// Ports:
//   clk_i         in   1  system clock, rising edge
//   rst_i         in   1  asynchronous reset, active low
//   opcode_i      in   6  IR[31:26], valid from DECODE onward
//   zero_i        in   1  ALU zero flag (branch resolution)
//   mem_ready_i   in   1  memory access completes this cycle
//   pc_write_o    out  1  PC load enable
//   pc_src_o      out  2  00 ALU result, 01 ALUOut, 10 jump target
//   iord_o        out  1  memory address: 0 PC, 1 ALUOut
//   mem_read_o    out  1  memory read strobe
//   mem_write_o   out  1  memory write strobe
//   ir_write_o    out  1  IR load enable
//   reg_dst_o     out  1  destination register: 0 rt, 1 rd
//   mem_to_reg_o  out  1  write-back data: 0 ALUOut, 1 MDR
//   reg_write_o   out  1  register file write enable
//   alu_src_a_o   out  1  ALU A: 0 PC, 1 rs
//   alu_src_b_o   out  2  ALU B: 00 rt, 01 4, 10 sext imm, 11 sext imm<<2
//   alu_op_o      out  2  00 funct decode, 01 add, 10 sub (beq), 11 sub (bne)
//   state_o       out  4  current state code, for debug
//   illegal_o     out  1  one-cycle pulse after an undecodable opcode
// ---------------------------------------------------------------------------
module multi_cycle_ctrl (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic [1:0] pc_src_o,
  output logic       iord_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [3:0] state_o,
  output logic       illegal_o
);

  // State codes are architecturally visible on state_o, so they are fixed.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTEXEC   = 4'd6,
    S_RTWB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     state_q;
  state_t     state_d;
  logic [5:0] op_q;        // opcode captured in DECODE
  logic       illegal_q;
  logic       illegal_d;

  // Decode-time dispatch from the live opcode.
  state_t     dispatch_state;
  logic       dispatch_illegal;

  // Raw (pre-reset-gating) versions of the handshake-qualified enables.
  logic       pc_write;
  logic       ir_write;

  // -------------------------------------------------------------------------
  // Opcode dispatch used by DECODE
  // -------------------------------------------------------------------------
  always_comb begin
    dispatch_state   = S_FETCH;
    dispatch_illegal = 1'b0;
    case (opcode_i)
      OP_RTYPE:      dispatch_state = S_RTEXEC;
      OP_LW, OP_SW:  dispatch_state = S_MEMADR;
      OP_BEQ,
      OP_BNE:        dispatch_state = S_BRANCH;
      OP_ADDI:       dispatch_state = S_ADDIEXEC;
`ifdef CTRL_JUMP_EN
      OP_J:          dispatch_state = S_JUMP;
`endif
      default: begin
        dispatch_state   = S_FETCH;
        dispatch_illegal = 1'b1;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State, latched opcode and illegal pulse registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_FETCH;
      op_q      <= 6'b000000;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      // The IR may be rewritten by later stages' perspective of the bus, so the
      // execute states work from this private copy.
      if (state_q == S_DECODE) begin
        op_q <= opcode_i;
      end
    end
  end

  // The pulse appears in the cycle after DECODE, i.e. the first FETCH cycle.
  assign illegal_d = (state_q == S_DECODE) && dispatch_illegal;

  // -------------------------------------------------------------------------
  // Next-state and output decode
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = S_FETCH;
    pc_write     = 1'b0;
    pc_src_o     = 2'b00;
    iord_o       = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    ir_write     = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    alu_op_o     = 2'b00;

    case (state_q)
      S_FETCH: begin
        // PC + 4 is computed every cycle; it is only committed (together with
        // the IR load) in the cycle memory returns the instruction.
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'b01;
        alu_op_o    = 2'b01;
        if (mem_ready_i) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else begin
          state_d  = S_FETCH;
        end
      end

      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        alu_src_b_o = 2'b11;
        alu_op_o    = 2'b01;
        state_d     = dispatch_state;
      end

      S_MEMADR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        alu_op_o    = 2'b01;
        state_d     = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
        state_d    = mem_ready_i ? S_MEMWB : S_MEMRD;
      end

      S_MEMWB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        state_d      = S_FETCH;
      end

      S_MEMWR: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
        state_d     = mem_ready_i ? S_FETCH : S_MEMWR;
      end

      S_RTEXEC: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 2'b00;
        state_d     = S_RTWB;
      end

      S_RTWB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
        state_d     = S_FETCH;
      end

      S_BRANCH: begin
        // Only beq and bne reach here, so "not beq" means bne.
        alu_src_a_o = 1'b1;
        pc_src_o    = 2'b01;
        if (op_q == OP_BEQ) begin
          alu_op_o = 2'b10;
          pc_write = zero_i;
        end else begin
          alu_op_o = 2'b11;
          pc_write = ~zero_i;
        end
        state_d = S_FETCH;
      end

      S_ADDIEXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        alu_op_o    = 2'b01;
        state_d     = S_ADDIWB;
      end

      S_ADDIWB: begin
        reg_write_o = 1'b1;
        state_d     = S_FETCH;
      end

`ifdef CTRL_JUMP_EN
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src_o = 2'b10;
        state_d  = S_FETCH;
      end
`endif

      default: begin
        // Unreachable codes (and JUMP when it is not built) recover to FETCH
        // with every strobe low.
        state_d = S_FETCH;
      end
    endcase
  end

  // While reset is held the register already sits in FETCH, but a ready from
  // memory must not be allowed to load the PC or IR.
  assign pc_write_o = pc_write & rst_i;
  assign ir_write_o = ir_write & rst_i;

  assign state_o   = state_q;
  assign illegal_o = illegal_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multi_cycle_ctrl
//
// Driver plans each instruction at the instruction level (which phases it
// walks through, how many memory wait cycles, the zero flag) and pushes the
// expected per-cycle control word into exp_q. A monitor on the falling edge
// pops one entry per out-of-reset cycle and compares it with the DUT outputs.
// Reset behaviour is checked directly while reset is held.
// ---------------------------------------------------------------------------
module tb_multi_cycle_ctrl;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ---------------- clock / reset ----------------
  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [5:0] opcode_i;
  logic       zero_i;
  logic       mem_ready_i;
  logic       pc_write_o;
  logic [1:0] pc_src_o;
  logic       iord_o;
  logic       mem_read_o;
  logic       mem_write_o;
  logic       ir_write_o;
  logic       reg_dst_o;
  logic       mem_to_reg_o;
  logic       reg_write_o;
  logic       alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic [1:0] alu_op_o;
  logic [3:0] state_o;
  logic       illegal_o;

  always #5 clk_i = ~clk_i;

  multi_cycle_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .opcode_i     (opcode_i),
    .zero_i       (zero_i),
    .mem_ready_i  (mem_ready_i),
    .pc_write_o   (pc_write_o),
    .pc_src_o     (pc_src_o),
    .iord_o       (iord_o),
    .mem_read_o   (mem_read_o),
    .mem_write_o  (mem_write_o),
    .ir_write_o   (ir_write_o),
    .reg_dst_o    (reg_dst_o),
    .mem_to_reg_o (mem_to_reg_o),
    .reg_write_o  (reg_write_o),
    .alu_src_a_o  (alu_src_a_o),
    .alu_src_b_o  (alu_src_b_o),
    .alu_op_o     (alu_op_o),
    .state_o      (state_o),
    .illegal_o    (illegal_o)
  );

  // ---------------- scoreboard state ----------------
  // Word layout: {state[3:0], pc_write, pc_src[1:0], iord, mem_read, mem_write,
  //               ir_write, reg_dst, mem_to_reg, reg_write, src_a, src_b[1:0],
  //               alu_op[1:0], illegal}
  logic [19:0] exp_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  bit          ill_pend = 1'b0;
  bit          stop_now = 1'b0;
  int          cyc      = 0;
  int          abort_at = 0;

  function automatic logic [18:0] cw(input logic [3:0] st, input logic pcw,
                                     input logic [1:0] pcs, input logic iord,
                                     input logic mr, input logic mw,
                                     input logic irw, input logic rd,
                                     input logic m2r, input logic rw,
                                     input logic sa, input logic [1:0] sb,
                                     input logic [1:0] aop);
    return {st, pcw, pcs, iord, mr, mw, irw, rd, m2r, rw, sa, sb, aop};
  endfunction

  function automatic logic [19:0] observed();
    return {state_o, pc_write_o, pc_src_o, iord_o, mem_read_o, mem_write_o,
            ir_write_o, reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o,
            alu_src_b_o, alu_op_o, illegal_o};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk_i) begin
    logic [19:0] got;
    logic [19:0] exp;
    if (rst_i === 1'b1) begin
      got = observed();
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL ctrl_underflow t=%0t got=%05h required=<no expectation>", $time, got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("FAIL ctrl_word t=%0t got state=%0d word=%05h required state=%0d word=%05h",
                   $time, got[19:16], got, exp[19:16], exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One planned cycle: drive inputs, record the expectation, advance a clock.
  task automatic step(input logic [18:0] w, input logic rdy, input logic z,
                      input logic [5:0] opc);
    if (stop_now) return;
    mem_ready_i = rdy;
    zero_i      = z;
    opcode_i    = opc;
    exp_q.push_back({w, ill_pend});
    ill_pend = 1'b0;
    @(posedge clk_i);
    #1;
    cyc++;
    if (cyc == abort_at) stop_now = 1'b1;
  endtask

  function automatic int pick_wait(input int mem_wait);
    return (mem_wait < 0) ? int'($urandom_range(0, 3)) : mem_wait;
  endfunction

  function automatic logic pick_zero(input int zsel);
    return (zsel < 0) ? logic'($urandom_range(0, 1)) : logic'(zsel[0]);
  endfunction

  function automatic logic [5:0] junk();
    return 6'($urandom);
  endfunction

  function automatic logic rnd_bit();
    return logic'($urandom_range(0, 1));
  endfunction

  // Memory access: wait cycles with the strobe held, then the ready cycle.
  task automatic mem_phase(input logic [18:0] w, input int waits, input int zsel);
    for (int i = 0; i < waits; i++) step(w, 1'b0, pick_zero(zsel), junk());
    step(w, 1'b1, pick_zero(zsel), junk());
  endtask

  // Run one instruction. mem_wait<0 randomises wait states, zsel<0 randomises
  // zero_i, abort_cyc>0 stops planning after that many cycles.
  task automatic run_instr(input logic [5:0] op, input int mem_wait,
                           input int zsel, input int abort_cyc);
    logic z;
    int   w;
    bit   legal;
    stop_now = 1'b0;
    cyc      = 0;
    abort_at = abort_cyc;
    // FETCH: PC and IR are loaded only in the ready cycle
    w = pick_wait(mem_wait);
    for (int i = 0; i < w; i++)
      step(cw(4'd0,0,2'b00,0,1,0,0,0,0,0,0,2'b01,2'b01), 1'b0, pick_zero(zsel), junk());
    step(cw(4'd0,1,2'b00,0,1,0,1,0,0,0,0,2'b01,2'b01), 1'b1, pick_zero(zsel), junk());
    // DECODE: the opcode is only guaranteed valid here
    step(cw(4'd1,0,2'b00,0,0,0,0,0,0,0,0,2'b11,2'b01), rnd_bit(), pick_zero(zsel), op);
    legal = 1'b1;
    case (op)
      OP_LW: begin
        step(cw(4'd2,0,2'b00,0,0,0,0,0,0,0,1,2'b10,2'b01), rnd_bit(), pick_zero(zsel), junk());
        mem_phase(cw(4'd3,0,2'b00,1,1,0,0,0,0,0,0,2'b00,2'b00), pick_wait(mem_wait), zsel);
        step(cw(4'd4,0,2'b00,0,0,0,0,0,1,1,0,2'b00,2'b00), rnd_bit(), pick_zero(zsel), junk());
      end
      OP_SW: begin
        step(cw(4'd2,0,2'b00,0,0,0,0,0,0,0,1,2'b10,2'b01), rnd_bit(), pick_zero(zsel), junk());
        mem_phase(cw(4'd5,0,2'b00,1,0,1,0,0,0,0,0,2'b00,2'b00), pick_wait(mem_wait), zsel);
      end
      OP_RTYPE: begin
        step(cw(4'd6,0,2'b00,0,0,0,0,0,0,0,1,2'b00,2'b00), rnd_bit(), pick_zero(zsel), junk());
        step(cw(4'd7,0,2'b00,0,0,0,0,1,0,1,0,2'b00,2'b00), rnd_bit(), pick_zero(zsel), junk());
      end
      OP_BEQ, OP_BNE: begin
        // beq takes the branch on zero, bne on non-zero
        z = pick_zero(zsel);
        step(cw(4'd8, (op == OP_BEQ) ? z : ~z, 2'b01, 0,0,0,0,0,0,0,1,2'b00,
                (op == OP_BEQ) ? 2'b10 : 2'b11), rnd_bit(), z, junk());
      end
      OP_ADDI: begin
        step(cw(4'd9,0,2'b00,0,0,0,0,0,0,0,1,2'b10,2'b01), rnd_bit(), pick_zero(zsel), junk());
        step(cw(4'd10,0,2'b00,0,0,0,0,0,0,1,0,2'b00,2'b00), rnd_bit(), pick_zero(zsel), junk());
      end
`ifdef CTRL_JUMP_EN
      OP_J: begin
        step(cw(4'd11,1,2'b10,0,0,0,0,0,0,0,0,2'b00,2'b00), rnd_bit(), pick_zero(zsel), junk());
      end
`endif
      default: legal = 1'b0;
    endcase
    // An undecodable opcode shows up as illegal_o in the next FETCH cycle.
    if (!legal && !stop_now) ill_pend = 1'b1;
  endtask

  // Hold reset for n cycles with ready high and check the FETCH/reset outputs.
  task automatic check_reset(input int n);
    logic [19:0] got;
    logic [19:0] exp;
    rst_i       = 1'b0;
    mem_ready_i = 1'b1;
    ill_pend    = 1'b0;
    exp = {cw(4'd0,0,2'b00,0,1,0,0,0,0,0,0,2'b01,2'b01), 1'b0};
    for (int i = 0; i < n; i++) begin
      zero_i   = rnd_bit();
      opcode_i = junk();
      @(negedge clk_i);
      got = observed();
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset_word t=%0t got state=%0d word=%05h required state=%0d word=%05h",
                 $time, got[19:16], got, exp[19:16], exp);
      end
    end
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [5:0] pool [8];
    logic [5:0] op;
    rst_i       = 1'b0;
    opcode_i    = 6'd0;
    zero_i      = 1'b0;
    mem_ready_i = 1'b1;
    pool = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_J, 6'b111111};

    check_reset(3);

    // Directed: zero-wait lw straight out of reset, sw with 3 write waits,
    // beq/bne with zero set, R-type, illegal, jump, addi.
    run_instr(OP_LW,    0,  -1, 0);
    run_instr(OP_SW,    3,  -1, 0);
    run_instr(OP_BEQ,   0,   1, 0);
    run_instr(OP_BNE,   0,   1, 0);
    run_instr(OP_BEQ,   1,   0, 0);
    run_instr(OP_BNE,   1,   0, 0);
    run_instr(OP_RTYPE, -1, -1, 0);
    run_instr(6'b111111, 0, -1, 0);
    run_instr(OP_J,     0,  -1, 0);
    run_instr(OP_ADDI,  -1, -1, 0);
    run_instr(OP_J,     2,  -1, 0);

    // Abort an sw while it waits in MEMWR; reset must kill the write strobe
    // even with memory reporting ready.
    run_instr(OP_SW, 3, -1, 8);
    stop_now = 1'b0;
    check_reset(2);

    // Randomised instruction stream, including arbitrary 6-bit opcodes.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 4) == 0) op = 6'($urandom);
      else                           op = pool[$urandom_range(0, 7)];
      run_instr(op, -1, -1, 0);
    end

    // One more FETCH wait cycle so a trailing illegal pulse is observed.
    step(cw(4'd0,0,2'b00,0,1,0,0,0,0,0,0,2'b01,2'b01), 1'b0, 1'b0, 6'd0);

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk_i);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain got=%0d pending required=0 pending", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
